frame_sequencer: RTL

Serial frame controller that sits between the serial input pin and the downstream arithmetic unit. It hunts the serial stream for the 8-bit sync pattern and deserializes the frame body: control byte, operand A, then operand B, all MSB first. It validates the opcode, issues one operation through a valid/ready handshake, then waits for completion with a timeout. It also keeps frame and error counters for status readback.

---
 rtl/frame_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Serial frame controller: hunts for a sync byte, deserializes control/A/B fields MSB first,
// issues one operation over valid/ready and waits for completion with a timeout.
module frame_sequencer #(
  parameter logic [7:0]  PATTERN = 8'h5A,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic        abort,
  input  logic        op_ready,
  input  logic        op_done,
  output logic        op_valid,
  output logic [7:0]  op_code,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        busy,
  output logic        sync_det,
  output logic        frame_err,
  output logic        timeout_err,
  output logic [7:0]  frame_count,
  output logic [7:0]  err_count
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StHunt,
    StCtrl,
    StOpa,
    StOpb,
    StIssue,
    StWaitDone
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      window_q, window_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      op_code_q, op_code_d;
  logic [15:0]     op_a_q, op_a_d;
  logic [15:0]     op_b_q, op_b_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            sync_det_q, sync_det_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_err_q, timeout_err_d;

  logic [7:0] hunt_word;
  logic [7:0] ctrl_word;
  logic       hunt_full;
  logic       sync_hit;
  logic       ctrl_legal;
  logic       byte_last;
  logic       word_last;
  logic       tmo_hit;
  logic [7:0] err_count_inc;

  // In HUNT the bit counter tracks window fill, so a match needs 8 fresh bits after any clear.
  assign hunt_word     = {window_q[6:0], din};
  assign hunt_full     = (bit_cnt_q == 4'd7);
  assign sync_hit      = hunt_full && (hunt_word == PATTERN);
  assign ctrl_word     = {op_code_q[6:0], din};
  assign ctrl_legal    = (ctrl_word[7:3] == 5'd0) && (ctrl_word[2:0] != 3'd0);
  assign byte_last     = (bit_cnt_q == 4'd7);
  assign word_last     = (bit_cnt_q == 4'd15);
  assign tmo_hit       = (tmo_cnt_q == TmoLast);
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StHunt;
    end else begin
      unique case (state_q)
        StHunt:     if (sync_hit) state_d = StCtrl;
        StCtrl:     if (byte_last) state_d = ctrl_legal ? StOpa : StHunt;
        StOpa:      if (word_last) state_d = StOpb;
        StOpb:      if (word_last) state_d = StIssue;
        StIssue:    if (op_ready) state_d = StWaitDone;
        StWaitDone: if (op_done || tmo_hit) state_d = StHunt;
        default:    state_d = StHunt;
      endcase
    end
  end

  // Outputs
  always_comb begin
    op_valid    = (state_q == StIssue);
    busy        = (state_q != StHunt);
    op_code     = op_code_q;
    op_a        = op_a_q;
    op_b        = op_b_q;
    sync_det    = sync_det_q;
    frame_err   = frame_err_q;
    timeout_err = timeout_err_q;
    frame_count = frame_count_q;
    err_count   = err_count_q;
  end

  // Datapath next-state
  always_comb begin
    window_d      = window_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    op_code_d     = op_code_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    sync_det_d    = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    if (abort) begin
      window_d  = '0;
      bit_cnt_d = '0;
      tmo_cnt_d = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (sync_hit) begin
            window_d   = '0;
            bit_cnt_d  = '0;
            sync_det_d = 1'b1;
          end else begin
            window_d = hunt_word;
            if (!hunt_full) bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StCtrl: begin
          op_code_d = ctrl_word;
          if (byte_last) begin
            bit_cnt_d = '0;
            if (!ctrl_legal) begin
              frame_err_d = 1'b1;
              err_count_d = err_count_inc;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StOpa: begin
          op_a_d    = {op_a_q[14:0], din};
          bit_cnt_d = word_last ? 4'd0 : bit_cnt_q + 4'd1;
        end
        StOpb: begin
          op_b_d    = {op_b_q[14:0], din};
          bit_cnt_d = word_last ? 4'd0 : bit_cnt_q + 4'd1;
        end
        StIssue: begin
          tmo_cnt_d = '0;
        end
        StWaitDone: begin
          // Completion takes precedence over a timeout on the same edge.
          if (op_done) begin
            frame_count_d = frame_count_q + 8'd1;
          end else if (tmo_hit) begin
            timeout_err_d = 1'b1;
            err_count_d   = err_count_inc;
          end
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      window_q      <= '0;
      bit_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      op_code_q     <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      sync_det_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      window_q      <= window_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      op_code_q     <= op_code_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      sync_det_q    <= sync_det_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
